// File: rtl/motion_pkg.sv
// Shared motion types and default widths for the sprite motion controller,
// renderer and collision blocks.
package motion_pkg;

   localparam int MOTION_POS_W = 8;
   localparam int MOTION_VEL_W = 6;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      FALLING  = 2'd2
   } motion_state_t;

endpackage

// File: rtl/sat_add_signed.sv
// Unsigned position plus signed velocity, clamped to [0, 2^POS_W-1] so the
// sprite never wraps across the screen edge.
module sat_add_signed
   import motion_pkg::*;
#(
   parameter int POS_W = MOTION_POS_W,
   parameter int VEL_W = MOTION_VEL_W
)(
   input  logic [POS_W-1:0] base,
   input  logic [VEL_W-1:0] delta,
   output logic [POS_W-1:0] result
);

   // Two guard bits: one for sign, one for overflow past the top of the range.
   localparam int SUM_W = POS_W + 2;

   logic signed [SUM_W-1:0] sum;

   assign sum = $signed({2'b00, base}) + $signed({{(SUM_W-VEL_W){delta[VEL_W-1]}}, delta});

   always_comb begin
      if (sum[SUM_W-1])
         result = '0;
      else if (sum[SUM_W-2])
         result = '1;
      else
         result = sum[POS_W-1:0];
   end

endmodule

// File: rtl/character_motion_ctrl.sv
// Per-frame player sprite motion: walking, jumping with gravity and capped fall,
// jump buffering and collision blocking. Advances once per enable tick.
module character_motion_ctrl
   import motion_pkg::*;
#(
   parameter int POS_W      = MOTION_POS_W,
   parameter int VEL_W      = MOTION_VEL_W,
   parameter int X_INIT     = 72,
   parameter int Y_INIT     = 0,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 152,
   parameter int WALK_SPEED = 2,
   parameter int JUMP_V     = 12,
   parameter int GRAVITY    = 1,
   parameter int MAX_FALL   = 8,
   parameter int JUMP_BUF   = 3
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             jump,
   input  logic             move_left,
   input  logic             move_right,
   input  logic             left_blocked,
   input  logic             right_blocked,
   input  logic             up_blocked,
   input  logic             down_blocked,
   output logic [POS_W-1:0] x_position,
   output logic [POS_W-1:0] y_position,
   output logic [VEL_W-1:0] y_velocity,
   output logic [1:0]       motion_state,
   output logic             facing_left
);

   localparam int BUF_W = $clog2(JUMP_BUF + 1);

   localparam logic signed [VEL_W-1:0] JUMP_VEL   = VEL_W'(-JUMP_V);
   localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
   localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);
   localparam logic [POS_W:0]          WALK_E     = (POS_W+1)'(WALK_SPEED);
   localparam logic [POS_W:0]          X_MIN_E    = (POS_W+1)'(X_MIN);
   localparam logic [POS_W:0]          X_MAX_E    = (POS_W+1)'(X_MAX);

   logic [POS_W-1:0]        x_reg, x_next;
   logic [POS_W-1:0]        y_reg, y_next;
   logic signed [VEL_W-1:0] vy_reg, vy_next;
   motion_state_t           state_reg, state_next;
   logic                    face_reg, face_next;
   logic                    jump_prev_reg;
   logic [BUF_W-1:0]        buf_reg, buf_next;

   logic                    jump_rise;
   logic                    buf_armed;
   logic [BUF_W-1:0]        buf_dec;
   logic signed [VEL_W-1:0] vy_grav;
   logic [POS_W-1:0]        y_sum;
   logic [POS_W:0]          x_ext, x_plus;
   logic [POS_W-1:0]        x_minus;

   sat_add_signed #(.POS_W(POS_W), .VEL_W(VEL_W)) u_y_add (
      .base   (y_reg),
      .delta  (vy_reg),
      .result (y_sum)
   );

   assign jump_rise = jump & ~jump_prev_reg;
   assign buf_dec   = (buf_reg != '0) ? buf_reg - BUF_W'(1) : '0;
   assign buf_armed = jump_rise | (buf_reg != '0);
   assign vy_grav   = vy_reg + GRAV_V;
   assign x_ext     = {1'b0, x_reg};
   assign x_plus    = x_ext + WALK_E;
   assign x_minus   = x_reg - WALK_E[POS_W-1:0];

   always_comb begin
      x_next     = x_reg;
      y_next     = y_reg;
      vy_next    = vy_reg;
      state_next = state_reg;
      face_next  = face_reg;
      buf_next   = jump_rise ? BUF_W'(JUMP_BUF) : buf_dec;

      // Wedged between floor and ceiling: freeze vertical motion and settle.
      if (up_blocked && down_blocked) begin
         state_next = GROUNDED;
      end else begin
         case (state_reg)
            GROUNDED: begin
               if (buf_armed && !up_blocked) begin
                  vy_next    = JUMP_VEL;
                  buf_next   = '0;
                  state_next = RISING;
               end else begin
                  vy_next = '0;
                  if (!down_blocked)
                     state_next = FALLING;
               end
            end
            RISING: begin
               if (up_blocked) begin
                  vy_next    = '0;
                  state_next = FALLING;
               end else begin
                  y_next  = y_sum;
                  vy_next = vy_grav;
                  if (!vy_grav[VEL_W-1])
                     state_next = FALLING;
               end
            end
            FALLING: begin
               if (down_blocked) begin
                  vy_next    = '0;
                  state_next = GROUNDED;
               end else begin
                  y_next  = y_sum;
                  vy_next = (vy_grav > MAX_FALL_V) ? MAX_FALL_V : vy_grav;
               end
            end
            default: state_next = FALLING;
         endcase
      end

      // Horizontal walking is independent of the vertical state.
      if (move_left ^ move_right) begin
         face_next = move_left;
         if (move_left && !left_blocked)
            x_next = (x_ext < X_MIN_E + WALK_E) ? X_MIN_E[POS_W-1:0] : x_minus;
         if (move_right && !right_blocked)
            x_next = (x_plus > X_MAX_E) ? X_MAX_E[POS_W-1:0] : x_plus[POS_W-1:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_reg         <= POS_W'(X_INIT);
         y_reg         <= POS_W'(Y_INIT);
         vy_reg        <= '0;
         state_reg     <= FALLING;
         face_reg      <= 1'b0;
         jump_prev_reg <= 1'b0;
         buf_reg       <= '0;
      end else if (enable) begin
         x_reg         <= x_next;
         y_reg         <= y_next;
         vy_reg        <= vy_next;
         state_reg     <= state_next;
         face_reg      <= face_next;
         jump_prev_reg <= jump;
         buf_reg       <= buf_next;
      end
   end

   assign x_position   = x_reg;
   assign y_position   = y_reg;
   assign y_velocity   = vy_reg;
   assign motion_state = state_reg;
   assign facing_left  = face_reg;

endmodule
